// File: rtl/hyperthermia_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : hyperthermia_sequencer
//  Description : Control FSM for the hyperthermia-prevention datapath.
//                Schedules one input-register load (en_in) every SAMPLE_DIV
//                cycles. It commits the logic-module result to the output
//                register (en_out) only after that result has persisted:
//                CONFIRM_N matching samples to raise the level, CLEAR_N
//                matching samples to lower it.
//  Ports       : clk    - system clock
//                rst    - asynchronous active-high reset
//                active - system enable (synchronous, level-sensitive)
//                log    - logic-module result (00 none, 01 vent, 10 alarm,
//                         11 alarm+vent), valid the cycle after en_in
//                en_in  - one-cycle load strobe to the input register
//                en_out - one-cycle load strobe to the output register
//                level  - committed output level (mirrors output register)
//                state  - FSM state code for display/debug
//  Revision    : 1.0 - initial release
// ============================================================================
module hyperthermia_sequencer #(
  parameter int SAMPLE_DIV = 1000,
  parameter int CONFIRM_N  = 3,
  parameter int CLEAR_N    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       active,
  input  logic [1:0] log,
  output logic       en_in,
  output logic       en_out,
  output logic [1:0] level,
  output logic [2:0] state
);

  localparam int                 c_CNT_W    = $clog2(SAMPLE_DIV);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SAMPLE_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [3:0]         c_THR_UP   = 4'(CONFIRM_N);
  localparam logic [3:0]         c_THR_DN   = 4'(CLEAR_N);
  localparam logic [3:0]         c_MCNT_MAX = 4'd15;

  localparam logic [2:0] c_IDLE   = 3'b000;
  localparam logic [2:0] c_LOAD   = 3'b001;
  localparam logic [2:0] c_EVAL   = 3'b010;
  localparam logic [2:0] c_COMMIT = 3'b011;
  localparam logic [2:0] c_WAIT   = 3'b100;

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [1:0]         r_cand;
  logic [3:0]         r_mcnt;
  logic [1:0]         r_level;

  logic [1:0]         w_cand_upd;
  logic [3:0]         w_mcnt_upd;
  logic [3:0]         w_thr;
  logic               w_commit;

  // Persistence filter, evaluated against the log value present this cycle.
  // Only consumed while the FSM sits in EVAL.
  always_comb begin
    w_cand_upd = r_cand;
    w_mcnt_upd = r_mcnt;
    if (log == r_level) begin
      // Result agrees with the committed level: drop any pending change.
      w_cand_upd = r_level;
      w_mcnt_upd = 4'd0;
    end else if (log == r_cand) begin
      w_mcnt_upd = (r_mcnt == c_MCNT_MAX) ? c_MCNT_MAX : r_mcnt + 4'd1;
    end else begin
      w_cand_upd = log;
      w_mcnt_upd = 4'd1;
    end
    w_thr    = (log > r_level) ? c_THR_UP : c_THR_DN;
    w_commit = (log != r_level) && (w_mcnt_upd >= w_thr);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; deasserted active overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    if (!active) begin
      w_state_nxt = c_IDLE;
    end else begin
      case (r_state)
        c_IDLE:   w_state_nxt = c_LOAD;
        c_LOAD:   w_state_nxt = c_EVAL;
        c_EVAL:   w_state_nxt = w_commit ? c_COMMIT : c_WAIT;
        c_COMMIT: w_state_nxt = c_WAIT;
        c_WAIT:   w_state_nxt = (r_cnt == c_CNT_LAST) ? c_LOAD : c_WAIT;
        default:  w_state_nxt = c_IDLE;
      endcase
    end
  end

  // Datapath registers: period counter, candidate, match count, level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_cand  <= 2'b00;
      r_mcnt  <= 4'd0;
      r_level <= 2'b00;
    end else begin
      // The COMMIT state is already registered, so the commit completes
      // even if active falls during this cycle.
      if (r_state == c_COMMIT) begin
        r_level <= r_cand;
      end
      if (!active) begin
        r_cnt  <= '0;
        r_cand <= 2'b00;
        r_mcnt <= 4'd0;
      end else begin
        if (r_state == c_IDLE) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + c_CNT_ONE;
        end
        if (r_state == c_EVAL) begin
          r_cand <= w_cand_upd;
          r_mcnt <= w_mcnt_upd;
        end
        if (r_state == c_COMMIT) begin
          r_mcnt <= 4'd0;
        end
      end
    end
  end

  // Moore outputs
  always_comb begin
    en_in  = (r_state == c_LOAD);
    en_out = (r_state == c_COMMIT);
    level  = r_level;
    state  = r_state;
  end

endmodule
`default_nettype wire

// File: tb/tb_hyperthermia_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hyperthermia_sequencer
//  Description : Self-checking bench for hyperthermia_sequencer: a vector
//                table, hand-written corner sequences and randomized traffic
//                checked against a sample-period reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hyperthermia_sequencer;

  localparam int DIV  = 8;
  localparam int CONF = 3;
  localparam int CLR  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       active;
  logic [1:0] lg;
  logic       en_in;
  logic       en_out;
  logic [1:0] level;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hyperthermia_sequencer #(
    .SAMPLE_DIV (DIV),
    .CONFIRM_N  (CONF),
    .CLEAR_N    (CLR)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .active (active),
    .log    (lg),
    .en_in  (en_in),
    .en_out (en_out),
    .level  (level),
    .state  (state)
  );

  // Reference model. Tracked as position within the sample period
  // (-1 = idle) plus the filter's level/candidate/count.
  // Position 0 = load, 1 = evaluate, 2 = commit slot (if one is pending).
  int         m_pos;
  logic [1:0] m_level;
  logic [1:0] m_cand;
  int         m_mcnt;
  bit         m_pend;

  task automatic model_reset();
    m_pos = -1; m_level = 2'b00; m_cand = 2'b00; m_mcnt = 0; m_pend = 0;
  endtask

  task automatic model_edge(input logic a, input logic [1:0] l);
    if (m_pos == 2 && m_pend) begin
      m_level = m_cand;
      m_mcnt  = 0;
    end
    if (!a) begin
      m_pos = -1; m_cand = 2'b00; m_mcnt = 0; m_pend = 0;
    end else if (m_pos < 0) begin
      m_pos = 0; m_pend = 0;
    end else begin
      if (m_pos == 1) begin
        if (l == m_level) begin
          m_cand = m_level; m_mcnt = 0; m_pend = 0;
        end else begin
          if (l == m_cand) m_mcnt = (m_mcnt >= 15) ? 15 : m_mcnt + 1;
          else begin m_cand = l; m_mcnt = 1; end
          m_pend = (m_mcnt >= ((l > m_level) ? CONF : CLR));
        end
      end else if (m_pos == 2) begin
        m_pend = 0;
      end
      m_pos = (m_pos + 1) % DIV;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic [2:0] es;
    if (m_pos < 0)                es = 3'b000;
    else if (m_pos == 0)          es = 3'b001;
    else if (m_pos == 1)          es = 3'b010;
    else if (m_pos == 2 && m_pend) es = 3'b011;
    else                          es = 3'b100;
    chk({tag, ".state"},  32'(state),  32'(es));
    chk({tag, ".en_in"},  32'(en_in),  32'(m_pos == 0));
    chk({tag, ".en_out"}, 32'(en_out), 32'(m_pos == 2 && m_pend));
    chk({tag, ".level"},  32'(level),  32'(m_level));
  endtask

  // One clock: drive at negedge, model follows the posedge, check at negedge.
  task automatic cycle(input logic a, input logic [1:0] l, input string tag);
    active = a;
    lg     = l;
    @(posedge clk);
    model_edge(a, l);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic run_sample(input logic [1:0] l, input string tag);
    for (int i = 0; i < DIV; i++) cycle(1'b1, l, tag);
  endtask

  task automatic sync_reset_pulse();
    rst = 1'b1;
    active = 1'b0;
    #1;
    model_reset();
    check_model("async_rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       active;
    logic [1:0] log;
    logic       en_in;
    logic       en_out;
    logic [1:0] level;
    logic [2:0] state;
  } vec_t;

  vec_t tbl[24];

  initial begin
    int n_pulse;
    int n_out;

    // Escalation vectors: active=1, log=10 from the first sample.
    // Loads at entries 0,8,16; evals at 1,9,17; third eval commits -> 18.
    for (int k = 0; k < 24; k++) begin
      tbl[k].active = 1'b1;
      tbl[k].log    = 2'b10;
      tbl[k].en_in  = 1'b0;
      tbl[k].en_out = 1'b0;
      tbl[k].level  = (k >= 19) ? 2'b10 : 2'b00;
      tbl[k].state  = 3'b100;
      if (k % 8 == 0) begin tbl[k].state = 3'b001; tbl[k].en_in = 1'b1; end
      if (k % 8 == 1) tbl[k].state = 3'b010;
    end
    tbl[18].state  = 3'b011;
    tbl[18].en_out = 1'b1;

    rst = 1'b1; active = 1'b0; lg = 2'b00;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset.state",  32'(state),  32'd0);
    chk("reset.en_in",  32'(en_in),  32'd0);
    chk("reset.en_out", 32'(en_out), 32'd0);
    chk("reset.level",  32'(level),  32'd0);
    rst = 1'b0;

    for (int k = 0; k < 24; k++) begin
      active = tbl[k].active;
      lg     = tbl[k].log;
      @(posedge clk);
      model_edge(tbl[k].active, tbl[k].log);
      @(negedge clk);
      chk($sformatf("vec%0d.state", k),  32'(state),  32'(tbl[k].state));
      chk($sformatf("vec%0d.en_in", k),  32'(en_in),  32'(tbl[k].en_in));
      chk($sformatf("vec%0d.en_out", k), 32'(en_out), 32'(tbl[k].en_out));
      chk($sformatf("vec%0d.level", k),  32'(level),  32'(tbl[k].level));
    end

    // Asynchronous reset mid-run with level = 10.
    #2 rst = 1'b1;
    #1;
    chk("midrst.state",  32'(state),  32'd0);
    chk("midrst.en_in",  32'(en_in),  32'd0);
    chk("midrst.en_out", 32'(en_out), 32'd0);
    chk("midrst.level",  32'(level),  32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 2'b00, "rel");
    chk("rel.first_en_in", 32'(en_in), 32'd1);

    // log = 00 for 5 periods: 5 loads, no outputs.
    n_pulse = 1; n_out = 0;
    for (int i = 1; i < 5 * DIV; i++) begin
      cycle(1'b1, 2'b00, "quiet");
      if (en_in)  n_pulse++;
      if (en_out) n_out++;
    end
    chk("quiet.en_in_count",  32'(n_pulse), 32'd5);
    chk("quiet.en_out_count", 32'(n_out),   32'd0);

    // Escalate to 10, then alternating 10/00 must never commit.
    for (int i = 0; i < 3; i++) run_sample(2'b10, "esc");
    chk("esc.level", 32'(level), 32'd2);
    run_sample(2'b10, "alt"); run_sample(2'b00, "alt");
    run_sample(2'b10, "alt"); run_sample(2'b00, "alt");
    chk("alt.level", 32'(level), 32'd2);

    // De-escalation to 01 after two samples.
    run_sample(2'b01, "deesc");
    chk("deesc1.level", 32'(level), 32'd2);
    run_sample(2'b01, "deesc");
    chk("deesc2.level", 32'(level), 32'd1);

    // 11,11,01 cancels; two more 11 samples are still short of three.
    run_sample(2'b11, "cancel"); run_sample(2'b11, "cancel");
    run_sample(2'b01, "cancel");
    run_sample(2'b11, "cancel"); run_sample(2'b11, "cancel");
    chk("cancel.level", 32'(level), 32'd1);

    // Active drop discards progress toward 11.
    sync_reset_pulse();
    for (int i = 0; i < 2 * DIV; i++) cycle(1'b1, 2'b11, "drop_pre");
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 2'b11, "drop_low");
      chk("drop_low.state", 32'(state), 32'd0);
    end
    n_out = 0;
    for (int i = 0; i < 2 * DIV; i++) begin
      cycle(1'b1, 2'b11, "drop_post");
      if (en_out) n_out++;
    end
    chk("drop_post.no_en_out", 32'(n_out), 32'd0);
    chk("drop_post.level",     32'(level), 32'd0);
    for (int i = 0; i < DIV; i++) cycle(1'b1, 2'b11, "drop_third");
    chk("drop_third.level", 32'(level), 32'd3);

    // Randomized traffic against the model.
    begin
      logic       ra;
      logic [1:0] rl;
      rl = 2'b00;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(999) < 3) begin
          sync_reset_pulse();
        end else begin
          ra = ($urandom_range(99) < 97);
          if ($urandom_range(5) == 0) rl = 2'($urandom_range(3));
          cycle(ra, rl, "rand");
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hyperthermia_sequencer.md
Name: hyperthermia_sequencer

Overview:
- Control FSM for the hyperthermia-prevention datapath: schedules periodic sampling of the input register (en_in) and update of the alarm/vent output register (en_out).
- Adds persistence filtering. A new logic-module result is committed to the output register only after it repeats on consecutive samples: CONFIRM_N samples to escalate, CLEAR_N samples to de-escalate.
- Sits between the top-level system's active/m_rst inputs and the Reg_In/Modulo_Logica/Reg_Out chain.

Parameters:
- SAMPLE_DIV, 1000: clock cycles per sample period. Legal range is 4 or more.
- CONFIRM_N, 3: consecutive matching samples required to commit a higher level. Legal range is 1..15.
- CLEAR_N, 2: consecutive matching samples required to commit a lower level. Legal range is 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Asynchronous, active-high.
- active  in  1  system enable. Synchronous, level-sensitive.
- log  in  2  combinational result from the logic module. 00 = none, 01 = vent, 10 = alarm, 11 = alarm+vent. Valid the cycle after en_in.
- en_in  out  1  one-cycle load strobe to the input register.
- en_out  out  1  one-cycle load strobe to the output register.
- level  out  2  currently committed output level; mirrors the output register contents.
- state  out  3  FSM state code, for display and debug.

Behaviour:
- Reset is asynchronous and active-high; clk is the only clock.
- Values on reset:
  - state = IDLE (000)
  - en_in = 0, en_out = 0, level = 00
  - period counter cnt = 0, candidate cand = 00, match counter mcnt = 0
- State encoding: IDLE = 000, LOAD = 001, EVAL = 010, COMMIT = 011, WAIT = 100.
- Outputs are Moore, decoded from the registered state:
  - en_in = (state == LOAD)
  - en_out = (state == COMMIT)
- Period counter:
  - Held at 0 in IDLE.
  - In every other state, increments each cycle and wraps from SAMPLE_DIV-1 to 0.
  - LOAD always coincides with cnt = 0, so en_in pulses exactly every SAMPLE_DIV cycles while active = 1.
- Transitions:
  - IDLE -> LOAD when active = 1. The first strobe follows active rise by 1 cycle.
  - LOAD -> EVAL.
  - EVAL -> COMMIT if the commit condition holds, else -> WAIT.
  - COMMIT -> WAIT.
  - WAIT -> LOAD when cnt == SAMPLE_DIV-1.
  - Any state -> IDLE on the cycle after active = 0. This takes priority over all other transitions.
- EVAL rules (log sampled in this cycle):
  - log == level: cand <= level, mcnt <= 0. Any pending change is cancelled.
  - log != level and log == cand: mcnt <= mcnt+1, saturating at 15.
  - log != level and log != cand: cand <= log, mcnt <= 1.
  - Required count: thr = CONFIRM_N if log > level (unsigned compare), else CLEAR_N.
  - Commit condition: log != level and the updated mcnt >= thr. When it holds, the next state is COMMIT.
- COMMIT:
  - level <= cand, mcnt <= 0, en_out = 1 for exactly one cycle.
  - At most one commit per sample period.
- Leaving to IDLE on active = 0:
  - cnt, mcnt and cand are cleared; level is retained.
  - No en_in or en_out is asserted in IDLE.
  - active dropping during LOAD or EVAL aborts the sample: no commit occurs.
  - active dropping in the COMMIT cycle still completes that commit, because the state is registered.
- Reset mid-operation: all registers return immediately to their reset values, including level = 00.
- With CONFIRM_N = 1, a single differing sample commits in the same period: LOAD, EVAL, COMMIT occupy cnt = 0, 1, 2.

Test Plan:
- Use SAMPLE_DIV = 8, CONFIRM_N = 3, CLEAR_N = 2 unless noted.
- rst = 1 mid-run with level = 10 -> asynchronously all outputs 0, state = 000, level = 00. After release with active = 1, en_in first pulses 1 cycle later.
- active = 1, log held 00 for 5 periods -> en_in pulses every 8 cycles (cycles 1, 9, 17, ...); en_out never asserts; level = 00.
- log = 10 held from the first sample -> en_out pulses once, 1 cycle after the third EVAL (cycle 19); level = 10. No further en_out.
- level = 10, log sequence 10,00,10,00 across samples -> mcnt alternates 0/1; no commit; level stays 10.
- level = 10, log = 01 for 2 samples -> de-escalation commits on the second sample; level = 01. Then log = 11,11,01 -> no commit; cand is cancelled on the 01 sample.
- active = 1, log = 11 for 2 samples, then active = 0 for 3 cycles, then active = 1 with log = 11 -> state = 000 during the low period; no en_out; level stays 00. Three fresh samples are needed, so the commit comes after the third EVAL.
